// File: rtl/layer_out_collector.sv
// Buffers one vector of N signed elements, tracks its max/argmax, and holds the result until the downstream side takes it.
// Defining LAYER_OUT_COLLECTOR_RELU_EN clamps each element to max(x,0) before it is stored and compared.
module layer_out_collector #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int LOGN  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] max_val,
  output logic [LOGN-1:0]         max_idx,
  input  logic [LOGN-1:0]         rd_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic [7:0]              vec_count
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [LOGN-1:0]         cnt;
  logic signed [WIDTH-1:0] mem [N];
  logic signed [WIDTH-1:0] elem;
  logic                    xfer, last, handoff, rd_ok;

  always_comb begin
    elem = data_in;
`ifdef LAYER_OUT_COLLECTOR_RELU_EN
    if (data_in[WIDTH-1]) elem = '0;
`endif
  end

  assign last  = (cnt == LOGN'(N - 1));
  // Only matters when N is not a power of two.
  assign rd_ok = ({{(32-LOGN){1'b0}}, rd_addr} < 32'(N));

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    xfer      = 1'b0;
    handoff   = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        xfer    = s_valid;
        if (s_valid && last) state_nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        handoff = m_ready;
        if (m_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      cnt       <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      rd_data   <= '0;
      vec_count <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        cnt <= last ? '0 : cnt + LOGN'(1);
        // Strict compare keeps the lowest index on ties; element 0 always seeds.
        if (cnt == '0 || elem > max_val) begin
          max_val <= elem;
          max_idx <= cnt;
        end
      end
      if (handoff) vec_count <= vec_count + 8'd1;
      rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && !reset) mem[cnt] <= elem;
  end

endmodule

// File: tb/tb_layer_out_collector.sv
// Scoreboard bench for layer_out_collector: stimulus pushes expected results, a negedge monitor pops on each handoff.
module tb_layer_out_collector;

  logic               clk = 1'b0;
  logic               reset, s_valid, m_ready;
  logic               s_ready, m_valid;
  logic signed [15:0] data_in, max_val, rd_data;
  logic [2:0]         max_idx, rd_addr;
  logic [7:0]         vec_count;

  typedef struct { int mv; int mi; int vc; } exp_t;
  exp_t q[$];

  int pass_cnt = 0;
  int total    = 0;
  int cycle    = 0;
  int exp_vc   = 0;

  layer_out_collector #(.WIDTH(16), .N(8), .LOGN(3)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .m_valid(m_valid), .m_ready(m_ready),
    .max_val(max_val), .max_idx(max_idx), .rd_addr(rd_addr),
    .rd_data(rd_data), .vec_count(vec_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: each output handshake is checked against the oldest expected result.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_max_val", int'(max_val), e.mv);
        chk("sb_max_idx", int'(max_idx), e.mi);
        chk("sb_vec_count", int'(vec_count), e.vc);
      end
    end
  end

  task automatic expect_result(input int mv, input int mi);
    exp_t e;
    e.mv = mv; e.mi = mi; e.vc = exp_vc;
    q.push_back(e);
    exp_vc = (exp_vc + 1) % 256;
  endtask

  // Drive one element; returns the cycle stamp of the accepting edge.
  task automatic send(input int v, output int cyc);
    int t;
    t = 0;
    cyc = -1;
    s_valid = 1'b1;
    data_in = 16'(v);
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
    end
    cyc = cycle;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input int v[8], output int first_cyc, output int last_cyc);
    int c;
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < 8; i++) begin
      send(v[i], c);
      if (i == 0) first_cyc = c;
      last_cyc = c;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_vc = 0;
  endtask

  task automatic release_result();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int basic[8] = '{5, -3, 12, 7, 12, 0, -8, 4};
    int neg[8]   = '{-20, -5, -9, -5, -100, -30, -6, -7};
    int ramp[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int after[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
    int wv[8];
    int fc, lc, lc_prev, c, prev_first, bad;

    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_max_val", int'(max_val), 0);
    chk("rst_max_idx", int'(max_idx), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_vec_count", int'(vec_count), 0);

    // Basic vector, m_ready already high: HOLD lasts one cycle.
    @(posedge clk); #1;
    m_ready = 1'b1;
    expect_result(12, 2);
    send_vec(basic, fc, lc);
    chk("basic_m_valid_after_last", int'(m_valid), 1);
    chk("basic_s_ready_low", int'(s_ready), 0);
    @(posedge clk); #1;
    chk("basic_m_valid_drop", int'(m_valid), 0);
    chk("basic_s_ready_back", int'(s_ready), 1);
    chk("basic_vec_count", int'(vec_count), 1);

    // Back-pressure: same vector, result held for 10 cycles, spurious s_valid ignored.
    m_ready = 1'b0;
    lc_prev = lc;
    expect_result(12, 2);
    send_vec(basic, fc, lc);
    chk("next_vec_two_edges", fc - lc_prev, 2);
    s_valid = 1'b1;
    data_in = 16'sd99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_m_valid", int'(m_valid), 1);
      chk("bp_s_ready", int'(s_ready), 0);
      chk("bp_max_val", int'(max_val), 12);
      chk("bp_max_idx", int'(max_idx), 2);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    release_result();
    chk("bp_vec_count", int'(vec_count), 2);

    // Negative vector plus readback in HOLD.
`ifdef LAYER_OUT_COLLECTOR_RELU_EN
    expect_result(0, 0);
`else
    expect_result(-5, 1);
`endif
    send_vec(neg, fc, lc);
    rd_addr = 3'd4;
    @(posedge clk); #1;
`ifdef LAYER_OUT_COLLECTOR_RELU_EN
    chk("neg_rd4", int'(rd_data), 0);
`else
    chk("neg_rd4", int'(rd_data), -100);
`endif
    rd_addr = 3'd1;
    @(posedge clk); #1;
`ifdef LAYER_OUT_COLLECTOR_RELU_EN
    chk("neg_rd1", int'(rd_data), 0);
`else
    chk("neg_rd1", int'(rd_data), -5);
`endif
    release_result();

    // Gapped input 1..8, then readback of index 3.
    expect_result(8, 7);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(ramp[i], c);
    end
    rd_addr = 3'd3;
    @(posedge clk); #1;
    chk("gap_rd3", int'(rd_data), 4);
    rd_addr = 3'd7;
    @(posedge clk); #1;
    chk("gap_rd7", int'(rd_data), 8);
    release_result();

    // Reset mid-vector discards the partial vector.
    for (int i = 0; i < 4; i++) send(50 + i, c);
    do_reset();
    chk("midrst_vec_count", int'(vec_count), 0);
    chk("midrst_s_ready", int'(s_ready), 1);
    m_ready = 1'b1;
    expect_result(9, 7);
    send_vec(after, fc, lc);
    @(posedge clk); #1;
    chk("midrst_after_count", int'(vec_count), 1);

    // 256 back-to-back vectors: vec_count wraps, N+1 cycles per vector.
    m_ready = 1'b0;
    do_reset();
    m_ready = 1'b1;
    bad = 0;
    prev_first = -1;
    for (int v = 0; v < 256; v++) begin
      for (int j = 0; j < 8; j++) wv[j] = (j == v % 8) ? 100 : j - 4;
      expect_result(100, v % 8);
      send_vec(wv, fc, lc);
      if (prev_first >= 0 && fc - prev_first != 9) bad++;
      prev_first = fc;
    end
    chk("wrap_throughput_violations", bad, 0);
    @(posedge clk); #1;
    chk("wrap_vec_count", int'(vec_count), 0);
    m_ready = 1'b0;

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/layer_out_collector.md
Name: layer_out_collector

Overview:
- Stream sink for the master side of a layer block. It accepts N signed output elements per vector over the s_valid/s_ready handshake and buffers them.
- It tracks a running maximum and its index, then presents the max value, argmax and a buffered readback port to the downstream classifier over m_valid/m_ready.
- It is the receiving end of the layer output stream and provides back-pressure to the layer while a completed result is waiting to be consumed.

Parameters:
- WIDTH, 16, element width (signed)
- N, 8, elements per vector
- LOGN, 3, index width, ceil(log2 N)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_valid  input  1  upstream element valid
- s_ready  output  1  collector can accept an element
- data_in  input  WIDTH  signed element from the layer
- m_valid  output  1  completed vector result available
- m_ready  input  1  downstream accepts the result
- max_val  output  WIDTH  signed maximum of the completed vector
- max_idx  output  LOGN  index of the maximum element
- rd_addr  input  LOGN  readback element index
- rd_data  output  WIDTH  buffered element at rd_addr
- vec_count  output  8  number of completed vectors handed off; wraps 255->0

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: s_ready=1, m_valid=0, max_val=0, max_idx=0, rd_data=0, vec_count=0, element counter=0, state=COLLECT. Buffer contents are not reset.
- A transfer occurs on any rising edge where s_valid && s_ready. The output handshake completes on m_valid && m_ready.
- State COLLECT (s_ready=1, m_valid=0):
  - Each transfer writes data_in to buf[cnt] and increments cnt.
  - Element 0 loads the running max unconditionally, with index 0.
  - Later elements replace the running max only if strictly greater (signed compare). On ties the lowest index wins.
  - The transfer with cnt==N-1 resets cnt to 0, updates max_val/max_idx including that element, and moves to HOLD.
  - In the cycle after that transfer, m_valid=1 and s_ready=0.
- State HOLD (s_ready=0, m_valid=1):
  - max_val and max_idx stay stable. s_valid is ignored and nothing is written.
  - On m_valid && m_ready: vec_count increments, state returns to COLLECT, and next cycle s_ready=1, m_valid=0.
  - If m_ready is already high on the first HOLD cycle, HOLD lasts exactly one cycle.
- Latency:
  - Last element accepted at edge k -> m_valid high after edge k.
  - Earliest next element is accepted at edge k+2 (one HOLD cycle).
- Readback: rd_data <= buf[rd_addr] on every edge, giving one cycle latency. Reads during COLLECT may return stale or partially updated data. Reads during HOLD are stable and valid.
- Arithmetic: all comparisons are signed WIDTH-bit. No width growth. Values are stored unmodified except as described under Optional Feature.
- Boundary conditions:
  - s_valid deasserted mid-vector: cnt holds and no timeout applies.
  - rd_addr >= N, when N is not a power of 2: rd_data=0.
  - Reset during COLLECT: the partial vector is discarded and cnt=0.
  - Reset during HOLD: the pending result is dropped, m_valid=0, and vec_count is not incremented.
  - m_ready high outside HOLD: no effect.
  - vec_count wraps 255->0.

Optional Feature:
- Macro LAYER_OUT_COLLECTOR_RELU_EN.
- Defined: each accepted element is clamped as max(data_in, 0) before the buffer write and before the max compare. A vector of all non-positive values yields max_val=0, max_idx=0.
- Undefined: elements are stored and compared as received, and negative maxima are reported.

Test Plan:
- Basic vector: after reset, stream 5,-3,12,7,12,0,-8,4 with m_ready=1 -> m_valid one cycle after the 8th transfer, max_val=12, max_idx=2 (tie resolves to lower index), s_ready low exactly one cycle, vec_count=1.
- Back-pressure: same vector with m_ready=0 for 10 cycles -> m_valid and outputs stable and s_ready=0 throughout. Extra s_valid pulses are ignored. Raising m_ready -> handoff, and the next vector is accepted starting two edges later.
- Negative vector: stream -20,-5,-9,-5,-100,-30,-6,-7 -> without the macro, max_val=-5, max_idx=1. With LAYER_OUT_COLLECTOR_RELU_EN, max_val=0, max_idx=0, and readback of index 4 returns 0.
- Gapped input plus readback: random s_valid gaps across 8 elements 1..8 -> max_val=8, max_idx=7. In HOLD, rd_addr=3 yields rd_data=4 one cycle later.
- Reset mid-vector: accept 4 elements, assert reset for 1 cycle, then stream 1,2,3,4,5,6,7,9 -> max_val=9, max_idx=7, vec_count=1 (partial vector never counted).
- Wrap: 256 back-to-back vectors with m_ready=1 -> vec_count returns to 0. Throughput is N+1 cycles per vector.
